bit_stream_serializer: RTL

- Upstream feeder for the serial-input sequence detector FSMs.
- Accepts a parallel word through a valid/ready handshake and shifts it out one bit per clock on a registered serial line, with a qualifying valid strobe.
- Supports back-to-back words with no idle gap, so the detector sees a contiguous bit stream across word boundaries.
- Emits a one-cycle frame_done pulse alongside the last bit of each word.

---
 rtl/bit_stream_serializer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bit_stream_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bit_stream_serializer                                           |
// | Purpose  : Valid/ready parallel-in, registered serial-out bit streamer.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bit_stream_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  input  logic [WIDTH-1:0]         load_data,
  output logic                     load_ready,
  output logic                     out,
  output logic                     out_valid,
  output logic                     frame_done,
  output logic [$clog2(WIDTH)-1:0] bit_index
);

  localparam int              c_CNT_W   = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_SHIFT = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic [WIDTH-1:0]   w_shifted;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               r_out;
  logic               r_out_valid;
  logic               r_frame_done;
  logic               w_out_nxt;
  logic               w_out_valid_nxt;
  logic               w_frame_done_nxt;
  logic               w_first_of_next;
  logic               w_last;
  logic               w_accept;

  // Rotation rather than zero-fill: the vacated bit is never presented,
  // and reading every bit keeps the register fully used.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted       = {r_shift[WIDTH-2:0], r_shift[WIDTH-1]};
      assign w_first_of_next = w_shift_nxt[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted       = {r_shift[0], r_shift[WIDTH-1:1]};
      assign w_first_of_next = w_shift_nxt[0];
    end
  endgenerate

  assign w_last     = (r_state == c_SHIFT) && (r_cnt == c_LAST);
  assign load_ready = (r_state == c_IDLE) || w_last;
  assign w_accept   = load_valid && load_ready;

  // State register plus registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= c_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_out        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_out        <= w_out_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // Next-state and datapath
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          w_state_nxt = c_SHIFT;
          w_shift_nxt = load_data;
          w_cnt_nxt   = '0;
        end
      end
      c_SHIFT: begin
        if (!w_last) begin
          w_shift_nxt = w_shifted;
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end else if (w_accept) begin
          w_shift_nxt = load_data;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = c_IDLE;
          w_shift_nxt = '0;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
        w_shift_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode; out is forced low whenever no payload is present
  always_comb begin
    w_out_valid_nxt  = (w_state_nxt == c_SHIFT);
    w_out_nxt        = w_out_valid_nxt && w_first_of_next;
    w_frame_done_nxt = w_out_valid_nxt && (w_cnt_nxt == c_LAST);
  end

  assign out        = r_out;
  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;
  assign bit_index  = r_cnt;

endmodule
`default_nettype wire
